// File: rtl/my_digit_leds_if.sv
// Peripheral bus bundle for the seven-segment display block: register
// select, byte write enables, write data and combinational readback.
interface my_digit_leds_if;
    logic        addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wen,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wen,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/my_digit_leds.sv
// Eight-digit common-anode seven-segment driver. The CPU writes a 32-bit
// hex value (DATA) and a per-digit enable mask (MASK); the block scans the
// digits one at a time, holding each for SCAN_DIV cycles, and drives
// active-low digit-select and segment lines from registers.
module my_digit_leds #(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    my_digit_leds_if.slave   bus,
    output logic [7:0]       dig_en,
    output logic [7:0]       dn_seg
);

    // Counter wide enough for 0..SCAN_DIV-1; at least one bit.
    localparam int unsigned      CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Hex nibble to active-low segments (bit0..6 = a..g, bit7 = dp kept off).
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic [31:0]      data_r;
    logic [7:0]       mask_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       dig_en_r;
    logic [7:0]       dn_seg_r;

    logic [31:0]      data_nxt_s;
    logic [7:0]       mask_nxt_s;
    logic             wrap_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [2:0]       idx_nxt_s;
    logic [3:0]       nibble_s;
    logic [7:0]       dig_en_nxt_s;
    logic [7:0]       dn_seg_nxt_s;

    // Register write decode: DATA takes individual bytes, MASK only byte 0.
    always_comb begin
        data_nxt_s = data_r;
        mask_nxt_s = mask_r;
        if (bus.addr == 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.wen[k]) begin
                    data_nxt_s[8*k +: 8] = bus.wdata[8*k +: 8];
                end else begin
                    data_nxt_s[8*k +: 8] = data_r[8*k +: 8];
                end
            end
        end else begin
            if (bus.wen[0]) begin
                mask_nxt_s = bus.wdata[7:0];
            end else begin
                mask_nxt_s = mask_r;
            end
        end
    end

    // Readback mux; shows registered contents, never the pending write data.
    always_comb begin
        bus.rdata = 32'h0000_0000;
        if (bus.addr == 1'b0) begin
            bus.rdata = data_r;
        end else begin
            bus.rdata = {24'h00_0000, mask_r};
        end
    end

    // Scan timing: cnt wraps after SCAN_DIV cycles and steps the digit index.
    always_comb begin
        wrap_s    = (cnt_r == CNT_LAST);
        cnt_nxt_s = cnt_r + CNT_ONE;
        idx_nxt_s = idx_r;
        if (wrap_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            idx_nxt_s = idx_r + 3'd1;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
            idx_nxt_s = idx_r;
        end
    end

    // Next display value for the current digit, blanked when masked off.
    always_comb begin
        nibble_s     = data_r[{idx_r, 2'b00} +: 4];
        dig_en_nxt_s = 8'hFF;
        dn_seg_nxt_s = 8'hFF;
        if (mask_r[idx_r]) begin
            dig_en_nxt_s = ~(8'h01 << idx_r);
            dn_seg_nxt_s = seg_decode(nibble_s);
        end else begin
            dig_en_nxt_s = 8'hFF;
            dn_seg_nxt_s = 8'hFF;
        end
    end

    // State registers: bus-visible registers, scan position and pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r   <= 32'h0000_0000;
            mask_r   <= 8'hFF;
            cnt_r    <= {CNT_W{1'b0}};
            idx_r    <= 3'd0;
            dig_en_r <= 8'hFF;
            dn_seg_r <= 8'hFF;
        end else begin
            data_r   <= data_nxt_s;
            mask_r   <= mask_nxt_s;
            cnt_r    <= cnt_nxt_s;
            idx_r    <= idx_nxt_s;
            dig_en_r <= dig_en_nxt_s;
            dn_seg_r <= dn_seg_nxt_s;
        end
    end

    assign dig_en = dig_en_r;
    assign dn_seg = dn_seg_r;

endmodule
